uart_instr_loader: RTL and testbench
====================================

// Module: uart_instr_loader
// PURPOSE
//  Sits between the UART byte receiver and the instruction memory. It packs
//  received byte pairs into 16-bit instruction words and writes them to
//  sequential addresses starting at ADDR_START. When the line has been idle
//  for a set time, it declares the load complete and reports the last
//  written address, so the CPU start logic and the status LED know the
//  program is ready.
// PARAMETERS
//  CYCLES_PER_BYTE      9548  clocks per UART frame (11 bits x 868 clocks at 100 MHz/115200)
//  MAX_DELAY_TOLERANCE  3     idle timeout in frames; TIMEOUT = CYCLES_PER_BYTE*MAX_DELAY_TOLERANCE
//  ADDR_START           1     first instruction address (address 0 stays unused)
//  ADDR_W               8     instruction address width
// PORTS
//  i_clk             in   1       system clock (100 MHz)
//  i_rst             in   1       synchronous reset, active-high
//  i_rx_data         in   8       received byte; valid only when i_rx_valid=1
//  i_rx_valid        in   1       one-cycle strobe per received byte
//  o_mem_we          out  1       one-cycle instruction-memory write strobe
//  o_mem_addr        out  ADDR_W  write address
//  o_mem_wdata       out  16      write data {high_byte, low_byte}
//  o_transmit_done   out  1       level; load finished, held until reset
//  o_max_addr_instr  out  ADDR_W  address of the last written instruction
//  o_odd_byte_err    out  1       level; timeout hit with an unpaired byte pending
//  o_busy            out  1       at least one byte received and load not done
// BEHAVIOUR
//  Reset: all outputs 0. State=WAIT_HI, next addr=ADDR_START, idle cnt=0,
//   hi-byte reg=0. Reset is honoured in every state and discards any pending
//   byte or partial load.
//  FSM states: WAIT_HI, WAIT_LO, DONE.
//  - WAIT_HI + i_rx_valid: latch byte as bits [15:8], go to WAIT_LO, o_busy=1.
//  - WAIT_LO + i_rx_valid: latch byte as bits [7:0], go to WAIT_HI.
//     On the next cycle: o_mem_we=1 for 1 cycle, o_mem_addr=current addr,
//     o_mem_wdata=word. In that same cycle o_max_addr_instr is set to addr
//     and addr is incremented.
//  - Latency: 1 clock from the accepting edge of the low byte to o_mem_we.
//     Back-to-back i_rx_valid on consecutive cycles is legal and loses no bytes.
//  - Idle counter: cleared on every i_rx_valid. Otherwise it increments each
//     clock while o_busy=1, and saturates at TIMEOUT.
//  - No timeout before the first byte; WAIT_HI with o_busy=0 waits forever.
//  - Timeout: o_transmit_done rises on the TIMEOUT-th clock edge after the
//     last accepted byte, and the FSM goes to DONE.
//     - In WAIT_HI: clean finish.
//     - In WAIT_LO: the pending high byte is dropped, no write occurs, and
//       o_odd_byte_err=1.
//  - Simultaneous i_rx_valid and timeout on the same edge: the byte wins, the
//     counter clears, and there is no DONE.
//  - Full: if a write targets address 2^ADDR_W-1, go to DONE on the same edge
//     as that write. Addr never wraps to 0.
//  - DONE: i_rx_valid is ignored and there are no writes. o_busy=0,
//     o_transmit_done=1, and o_max_addr_instr is held. Only i_rst leaves DONE.
//  - o_max_addr_instr stays 0 if no word was ever written, e.g. a single byte
//     followed by timeout.
// TESTING (CYCLES_PER_BYTE=10, MAX_DELAY_TOLERANCE=3, TIMEOUT=30)
//  1 Reset values: assert i_rst 3 cycles -> every output 0. Idle 100 cycles
//    with no rx -> o_transmit_done stays 0.
//  2 Pair pack: bytes 0x41, 0x00 ->
//    - o_mem_we pulses once with addr=1, wdata=0x4100.
//    - Next pair 0x81, 0x80 -> addr=2, wdata=0x8180.
//    - o_max_addr_instr=2.
//  3 Timeout: 11 pairs (22 bytes, last pair 0xE0, 0x00) then idle ->
//    - Last write has addr=11.
//    - o_transmit_done rises exactly 30 edges after the last byte.
//    - o_max_addr_instr=11, o_odd_byte_err=0.
//  4 Odd byte: 0x41, 0x00, 0x81, then idle ->
//    - One write only.
//    - o_transmit_done=1, o_odd_byte_err=1, o_max_addr_instr=1.
//  5 Boundary: a byte lands exactly on idle count 29->30.
//    Expected: no DONE; later bytes 0xFF at addr 255 -> write, then DONE.
//    Expected: a further byte is ignored (no o_mem_we).
//  6 Reset mid-load: i_rst after the high byte of pair 3.
//    Then send 0x41, 0x00 -> write at addr=1, wdata=0x4100.
//    After timeout: o_max_addr_instr=1.

Source files
------------

// File: rtl/uart_instr_loader.sv
// Packs UART byte pairs into 16-bit instruction words and writes them to sequential
// addresses. When the line stays idle long enough, it reports that the load is complete.
module uart_instr_loader #(
  parameter int CYCLES_PER_BYTE     = 9548,
  parameter int MAX_DELAY_TOLERANCE = 3,
  parameter int ADDR_START          = 1,
  parameter int ADDR_W              = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_transmit_done,
  output logic [ADDR_W-1:0] o_max_addr_instr,
  output logic              o_odd_byte_err,
  output logic              o_busy
);

  localparam int TIMEOUT = CYCLES_PER_BYTE * MAX_DELAY_TOLERANCE;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] WAIT_HI = 2'd0;
  localparam logic [1:0] WAIT_LO = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(ADDR_START);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  logic [1:0]        state_r;
  logic [7:0]        hi_r;
  logic [15:0]       word_r;
  logic              pend_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [15:0]       mem_wdata_r;
  logic              done_r;
  logic [ADDR_W-1:0] max_addr_r;
  logic              odd_err_r;
  logic              busy_r;
  logic              timeout_s;
  logic              full_s;

  // Timeout fires on the edge that would take the idle count to TIMEOUT; a byte on that edge wins.
  always_comb begin
    timeout_s = 1'b0;
    full_s    = 1'b0;
    if (busy_r && !i_rx_valid && (cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if (pend_r && (addr_r == ADDR_LAST)) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
  end

  // Byte packing, write pipeline, idle counter and load-state FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= WAIT_HI;
      hi_r        <= 8'h00;
      word_r      <= 16'h0000;
      pend_r      <= 1'b0;
      addr_r      <= ADDR_FIRST;
      cnt_r       <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 16'h0000;
      done_r      <= 1'b0;
      max_addr_r  <= '0;
      odd_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      pend_r   <= 1'b0;
      if (pend_r) begin
        mem_we_r    <= 1'b1;
        mem_addr_r  <= addr_r;
        mem_wdata_r <= word_r;
        max_addr_r  <= addr_r;
        // The final address is held rather than wrapping back to 0.
        if (addr_r != ADDR_LAST) begin
          addr_r <= addr_r + ADDR_ONE;
        end
      end

      if (i_rx_valid) begin
        cnt_r <= '0;
      end else if (busy_r && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end

      case (state_r)
        WAIT_HI: begin
          if (full_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else if (i_rx_valid) begin
            hi_r    <= i_rx_data;
            state_r <= WAIT_LO;
            busy_r  <= 1'b1;
          end else if (timeout_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        WAIT_LO: begin
          if (i_rx_valid) begin
            word_r  <= {hi_r, i_rx_data};
            pend_r  <= 1'b1;
            state_r <= WAIT_HI;
          end else if (timeout_s) begin
            state_r   <= DONE;
            done_r    <= 1'b1;
            odd_err_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r <= WAIT_HI;
        end
      endcase
    end
  end

  assign o_mem_we         = mem_we_r;
  assign o_mem_addr       = mem_addr_r;
  assign o_mem_wdata      = mem_wdata_r;
  assign o_transmit_done  = done_r;
  assign o_max_addr_instr = max_addr_r;
  assign o_odd_byte_err   = odd_err_r;
  assign o_busy           = busy_r;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader using a short frame time (TIMEOUT = 30 clocks).
module tb_uart_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        transmit_done;
  logic [7:0]  max_addr_instr;
  logic        odd_byte_err;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  uart_instr_loader #(
    .CYCLES_PER_BYTE(10),
    .MAX_DELAY_TOLERANCE(3),
    .ADDR_START(1),
    .ADDR_W(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_mem_we(mem_we),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_transmit_done(transmit_done),
    .o_max_addr_instr(max_addr_instr),
    .o_odd_byte_err(odd_byte_err),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int at_cyc);
    seen = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (transmit_done === 1'b1) begin
        seen = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [42:0] all_out;
    reset_dut();
    all_out = {mem_we, mem_addr, mem_wdata, transmit_done, max_addr_instr, odd_byte_err, busy};
    tests++;
    if (all_out !== 43'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h expected 0", all_out);
    end
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if ({transmit_done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_done: got done=%b busy=%b expected 0 0", transmit_done, busy);
    end
  endtask

  task automatic test_pair_pack();
    int base;
    reset_dut();
    base = wr_addr_q.size();
    send_byte(8'h41);
    tests++;
    if ({busy, mem_we} !== 2'b10) begin
      fails++;
      $display("FAIL hi_byte_busy: got busy=%b we=%b expected 1 0", busy, mem_we);
    end
    send_byte(8'h00);
    tests++;
    if (mem_we !== 1'b0) begin
      fails++;
      $display("FAIL write_latency: got we=%b expected 0 at low-byte edge", mem_we);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({mem_we, mem_addr, mem_wdata, max_addr_instr} !== {1'b1, 8'd1, 16'h4100, 8'd1}) begin
      fails++;
      $display("FAIL pair1_write: got we=%b addr=%0d data=%h max=%0d expected 1 1 4100 1",
               mem_we, mem_addr, mem_wdata, max_addr_instr);
    end
    @(posedge clk);
    #1;
    tests++;
    if (mem_we !== 1'b0) begin
      fails++;
      $display("FAIL we_one_cycle: got we=%b expected 0", mem_we);
    end
    send_byte(8'h81);
    send_byte(8'h80);
    @(posedge clk);
    #1;
    tests++;
    if ({mem_we, mem_addr, mem_wdata, max_addr_instr} !== {1'b1, 8'd2, 16'h8180, 8'd2}) begin
      fails++;
      $display("FAIL pair2_write: got we=%b addr=%0d data=%h max=%0d expected 1 2 8180 2",
               mem_we, mem_addr, mem_wdata, max_addr_instr);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (wr_addr_q.size() - base !== 2) begin
      fails++;
      $display("FAIL pair_write_count: got %0d expected 2", wr_addr_q.size() - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    int t0;
    int tc;
    bit seen;
    logic [7:0] b;
    reset_dut();
    base = wr_addr_q.size();
    for (int i = 0; i < 10; i++) begin
      b = 8'h10 + 8'(i);
      send_byte(b);
      b = 8'h20 + 8'(i);
      send_byte(b);
    end
    send_byte(8'hE0);
    send_byte(8'h00);
    t0 = last_cyc;
    wait_done(60, seen, tc);
    tests++;
    if (!seen || (tc - t0) != 30) begin
      fails++;
      $display("FAIL timeout_edge: got seen=%b edges=%0d expected 1 30", seen, tc - t0);
    end
    tests++;
    if (wr_addr_q.size() - base !== 11) begin
      fails++;
      $display("FAIL timeout_write_count: got %0d expected 11", wr_addr_q.size() - base);
    end else if ({wr_addr_q[base + 10], wr_data_q[base + 10]} !== {8'd11, 16'hE000}) begin
      fails++;
      $display("FAIL timeout_last_write: got addr=%0d data=%h expected 11 e000",
               wr_addr_q[base + 10], wr_data_q[base + 10]);
    end
    tests++;
    if ({max_addr_instr, odd_byte_err, busy} !== {8'd11, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL timeout_status: got max=%0d odd=%b busy=%b expected 11 0 0",
               max_addr_instr, odd_byte_err, busy);
    end
  endtask

  task automatic test_odd_byte();
    int base;
    int t0;
    int tc;
    bit seen;
    reset_dut();
    base = wr_addr_q.size();
    send_byte(8'h41);
    send_byte(8'h00);
    send_byte(8'h81);
    t0 = last_cyc;
    wait_done(60, seen, tc);
    tests++;
    if (!seen || (tc - t0) != 30) begin
      fails++;
      $display("FAIL odd_timeout_edge: got seen=%b edges=%0d expected 1 30", seen, tc - t0);
    end
    tests++;
    if (wr_addr_q.size() - base !== 1) begin
      fails++;
      $display("FAIL odd_write_count: got %0d expected 1", wr_addr_q.size() - base);
    end
    tests++;
    if ({transmit_done, odd_byte_err, max_addr_instr, busy} !== {1'b1, 1'b1, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL odd_status: got done=%b odd=%b max=%0d busy=%b expected 1 1 1 0",
               transmit_done, odd_byte_err, max_addr_instr, busy);
    end
  endtask

  task automatic test_boundary();
    int base;
    logic [7:0] a;
    reset_dut();
    base = wr_addr_q.size();
    send_byte(8'h12);
    repeat (29) @(posedge clk);
    #1;
    send_byte(8'h34);
    tests++;
    if ({transmit_done, busy} !== 2'b01) begin
      fails++;
      $display("FAIL boundary_no_done: got done=%b busy=%b expected 0 1", transmit_done, busy);
    end
    for (int i = 2; i < 255; i++) begin
      a = 8'(i);
      send_byte(a);
      send_byte(~a);
    end
    send_byte(8'hFF);
    send_byte(8'hFF);
    @(posedge clk);
    #1;
    tests++;
    if ({mem_we, mem_addr, mem_wdata, transmit_done, max_addr_instr, busy} !==
        {1'b1, 8'd255, 16'hFFFF, 1'b1, 8'd255, 1'b0}) begin
      fails++;
      $display("FAIL full_write: got we=%b addr=%0d data=%h done=%b max=%0d busy=%b expected 1 255 ffff 1 255 0",
               mem_we, mem_addr, mem_wdata, transmit_done, max_addr_instr, busy);
    end
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (wr_addr_q.size() - base !== 255) begin
      fails++;
      $display("FAIL full_ignore: got %0d writes expected 255", wr_addr_q.size() - base);
    end else if ({wr_addr_q[base], wr_data_q[base], wr_addr_q[base + 99], wr_data_q[base + 99]} !==
                 {8'd1, 16'h1234, 8'd100, 16'h649B}) begin
      fails++;
      $display("FAIL boundary_words: got %0d:%h %0d:%h expected 1:1234 100:649b",
               wr_addr_q[base], wr_data_q[base], wr_addr_q[base + 99], wr_data_q[base + 99]);
    end
    tests++;
    if ({transmit_done, max_addr_instr, odd_byte_err} !== {1'b1, 8'd255, 1'b0}) begin
      fails++;
      $display("FAIL full_hold: got done=%b max=%0d odd=%b expected 1 255 0",
               transmit_done, max_addr_instr, odd_byte_err);
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    int tc;
    bit seen;
    reset_dut();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h99);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({busy, max_addr_instr, transmit_done} !== {1'b0, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL midload_reset: got busy=%b max=%0d done=%b expected 0 0 0",
               busy, max_addr_instr, transmit_done);
    end
    base = wr_addr_q.size();
    send_byte(8'h41);
    send_byte(8'h00);
    @(posedge clk);
    #1;
    tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd1, 16'h4100}) begin
      fails++;
      $display("FAIL midload_write: got we=%b addr=%0d data=%h expected 1 1 4100",
               mem_we, mem_addr, mem_wdata);
    end
    wait_done(60, seen, tc);
    tests++;
    if ({seen, max_addr_instr, odd_byte_err} !== {1'b1, 8'd1, 1'b0} || wr_addr_q.size() - base != 1) begin
      fails++;
      $display("FAIL midload_done: got done=%b max=%0d odd=%b writes=%0d expected 1 1 0 1",
               seen, max_addr_instr, odd_byte_err, wr_addr_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_pair_pack();
    test_timeout();
    test_odd_byte();
    test_boundary();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
